// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv_basic memory subsystem: memory depth and
// the owner tag that steers a read response back to its requester.
package riscv_pkg;

   localparam int MEM_WORDS = 1024;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_FETCH,
      OWN_DATA
   } mem_owner_t;

endpackage

// File: rtl/imem_arbiter.sv
// Single-port memory arbiter: data port wins by default, fetch is forced
// through after STARVE_MAX consecutive data wins; read data returns one cycle later.
module imem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   logic [CNT_W-1:0] starve_cnt;
   mem_owner_t       rsp_owner_p1;
   mem_owner_t       owner_nxt;
   logic             starve_hit;
   logic             d_win;
   logic             if_win;
   logic             unused_addr_bits;

   // Byte offset and bits above the memory size are dropped; addresses wrap.
   assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                               d_addr[31:ADDR_W+2], d_addr[1:0]};

   assign starve_hit = (starve_cnt == CNT_MAX);

   // Grants are forced low while reset is held so the memory sees no access.
   always_comb begin
      d_win  = rst_n & d_req & ~(if_req & starve_hit);
      if_win = rst_n & if_req & ~d_win;
   end

   assign d_gnt  = d_win;
   assign if_gnt = if_win;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = '0;
      owner_nxt = OWN_NONE;
      if (d_win) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_we ? d_be : 4'hF;
         mem_addr  = d_addr[ADDR_W+1:2];
         mem_wdata = d_we ? d_wdata : 32'h0;
         owner_nxt = d_we ? OWN_NONE : OWN_DATA;
      end else if (if_win) begin
         mem_en    = 1'b1;
         mem_be    = 4'hF;
         mem_addr  = if_addr[ADDR_W+1:2];
         owner_nxt = OWN_FETCH;
      end
   end

   // Stage p1: response owner and starvation tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt   <= '0;
         rsp_owner_p1 <= OWN_NONE;
      end else begin
         rsp_owner_p1 <= owner_nxt;
         if (!if_req || if_win)
            starve_cnt <= '0;
         else if (d_win)
            starve_cnt <= sat_inc(starve_cnt);
      end
   end

   assign if_rvalid = (rsp_owner_p1 == OWN_FETCH);
   assign d_rvalid  = (rsp_owner_p1 == OWN_DATA);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port memory arbiter for the riscv_basic core. It shares one synchronous 1024-word memory between the instruction-fetch port and the load/store data port. Each cycle it grants at most one requester and drives the memory port. It returns read data to the granted requester one cycle later. Data accesses have priority, and a starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, default 10: word-address width of the memory (2^ADDR_W words).
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while fetch is pending.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out 32: fetch data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: store byte enables.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out 32: load data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out ADDR_W: memory word address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid one cycle after a read `mem_en`.

## Operation
- Word address is `addr[ADDR_W+1:2]`. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo 4·2^ADDR_W bytes.
- **Grant rule**, evaluated combinationally each cycle:
  - Only `d_req` is set: data is granted.
  - Only `if_req` is set: fetch is granted.
  - Both are set: data is granted, unless `starve_cnt == STARVE_MAX`, in which case fetch is granted.
  - Neither is set: no grant, and `mem_en` = 0.
- **Starvation counter** `starve_cnt`, range 0..STARVE_MAX, width clog2(STARVE_MAX+1):
  - Increments on a data grant while `if_req` = 1.
  - Clears on any fetch grant, or on any cycle with `if_req` = 0.
  - Saturates; it never wraps.
- **Memory drive**:
  - On a grant: `mem_en` = 1. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` come from the granted port.
  - Fetch grants are always reads: `mem_we` = 0, `mem_be` = 4'hF.
  - Data load: `mem_we` = 0, `mem_be` = 4'hF.
  - Data store: `mem_we` = 1, `mem_be` = `d_be`. A store with `d_be` = 0 is still granted and writes nothing.
  - With no grant, `mem_we` = 0 and `mem_be` = 0; `mem_addr` and `mem_wdata` are don't-care.
- **Response owner** register `rsp_owner` ∈ {NONE, FETCH, DATA}:
  - Loaded every cycle with the owner of a read grant, or NONE (stores and idle cycles).
  - `if_rvalid` = (`rsp_owner` == FETCH); `d_rvalid` = (`rsp_owner` == DATA).
  - `if_rdata` and `d_rdata` are both driven from `mem_rdata`, and are meaningful only while the matching rvalid is set.
- Stores produce no rvalid.

## Timing
- Grant and memory drive are combinational from the request inputs in the same cycle.
- A requester holds its request and operands stable until it sees `gnt`. After `gnt` it may change them or present a new request in the next cycle.
- Read latency is exactly 1 cycle: grant at cycle N gives rvalid at N+1.
- Throughput is one access per cycle. Back-to-back grants to the same port or to alternating ports are allowed, and rvalids then appear on consecutive cycles.
- A store granted at N followed by a load to the same word granted at N+1 returns the new data at N+2; the memory is write-first across cycles.
- **Reset**: `starve_cnt` = 0 and `rsp_owner` = NONE. Asserting `rst_n` low mid-transaction drops any pending rvalid immediately, with no response after release. All grant and `mem_*` outputs are 0 while reset is held low, regardless of requests.

## Structure
- Package `riscv_pkg` holds:
  - `MEM_WORDS` = 1024;
  - `typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} mem_owner_t`.
- No sub-module: the grant logic, counter and owner register are flat.
- The memory is external; the bench uses a synchronous 1024×32 byte-enabled model.

## Test plan
- **Fetch only**: `if_req` held for 3 cycles at 0x0, 0x4, 0x8 → `if_gnt` = 1 each cycle; `if_rvalid` on cycles 1–3 carrying words 0, 1, 2; `d_rvalid` never asserted.
- **Store then load**: store 0xDEADBEEF with `d_be` = 4'b0011 to 0x100 (old value 0x11223344), then load 0x100 → `d_rdata` = 0x1122BEEF one cycle after the load grant; no rvalid for the store.
- **Starvation**: `d_req` and `if_req` held for 10 cycles with `STARVE_MAX` = 4 → grant pattern D,D,D,D,F,D,D,D,D,F; each fetch rvalid follows its grant by 1 cycle.
- **Wrap and ignored bits**: load at 0x1004 and 0x0006 → both read word 1 of the memory.
- **Reset mid-read**: fetch granted at cycle N, `rst_n` low during N+1 → `if_rvalid` = 0 at N+1 and after release; first fetch after release is granted immediately with `starve_cnt` = 0.
